regfile_param: RTL and testbench

Parametrised register file, the next generation of the core's 32x32 register file. It provides two asynchronous read ports and one byte-enabled write port, an optional hardwired-zero register 0 and optional write-to-read bypass. A per-register pending-write scoreboard drives hazard detection, and a sequenced clear after reset sets every entry to zero. It sits between decode (read/reserve) and writeback (write) in the single-cycle datapath, and in future pipelined variants.

---
 rtl/regfile_param_if.sv | 32 +++
 rtl/regfile_param.sv | 112 +++++++++++
 tb/tb_regfile_param.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Register-file port bundle: two read ports, one byte-enabled write port,
// reserve request and scoreboard/ready status.
interface regfile_param_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0]   read_addr_1;
   logic [ADDR_WIDTH-1:0]   read_addr_2;
   logic [DATA_WIDTH-1:0]   read_data_1;
   logic [DATA_WIDTH-1:0]   read_data_2;
   logic [ADDR_WIDTH-1:0]   write_addr;
   logic [DATA_WIDTH-1:0]   write_data;
   logic [DATA_WIDTH/8-1:0] byte_en;
   logic                    reg_write;
   logic                    reserve;
   logic [ADDR_WIDTH-1:0]   reserve_addr;
   logic                    busy_1;
   logic                    busy_2;
   logic                    ready;

   modport master (
      output read_addr_1, read_addr_2, write_addr, write_data, byte_en, reg_write,
             reserve, reserve_addr,
      input  read_data_1, read_data_2, busy_1, busy_2, ready
   );

   modport slave (
      input  read_addr_1, read_addr_2, write_addr, write_data, byte_en, reg_write,
             reserve, reserve_addr,
      output read_data_1, read_data_2, busy_1, busy_2, ready
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: two async read ports, one byte-enabled write port,
// optional zero register and write bypass, pending-write scoreboard, clear after reset.
module regfile_param #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned ZERO_REG   = 1,
   parameter int unsigned BYPASS     = 1
) (
   input logic            clk,
   input logic            reset,
   regfile_param_if.slave bus
);
   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

   localparam logic [0:0] StClear = 1'b0;
   localparam logic [0:0] StRun   = 1'b1;

   logic [0:0]            state_q;
   logic [ADDR_WIDTH-1:0] clear_ptr_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]      pending_q;
   logic [DEPTH-1:0]      pending_d;

   logic                  running;
   logic                  wr_en;
   logic                  rsv_en;
   logic [DATA_WIDTH-1:0] wr_merged;
   logic [ADDR_WIDTH-1:0] rd_addr [2];
   logic [DATA_WIDTH-1:0] rd_data [2];
   logic                  rd_busy [2];

   assign running = (state_q == StRun);
   assign wr_en   = running && bus.reg_write &&
                    !((ZERO_REG != 0) && (bus.write_addr == '0));
   assign rsv_en  = running && bus.reserve &&
                    !((ZERO_REG != 0) && (bus.reserve_addr == '0));

   // Clear sequencer: the edge that clears the last entry hands over to RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StClear;
         clear_ptr_q <= '0;
      end else if (state_q == StClear) begin
         clear_ptr_q <= clear_ptr_q + 1'b1;
         if (&clear_ptr_q) begin
            state_q <= StRun;
         end
      end
   end

   always_comb begin
      wr_merged = mem_q[bus.write_addr];
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (bus.byte_en[i]) begin
            wr_merged[8*i +: 8] = bus.write_data[8*i +: 8];
         end
      end
   end

   // Storage is not touched by reset itself; the clear sequence zeroes it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == StClear) begin
            mem_q[clear_ptr_q] <= '0;
         end else if (wr_en) begin
            mem_q[bus.write_addr] <= wr_merged;
         end
      end
   end

   // Reserve is applied after the write-clear so it wins on an address collision.
   always_comb begin
      pending_d = pending_q;
      if (running && bus.reg_write) begin
         pending_d[bus.write_addr] = 1'b0;
      end
      if (rsv_en) begin
         pending_d[bus.reserve_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign rd_addr[0] = bus.read_addr_1;
   assign rd_addr[1] = bus.read_addr_2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = mem_q[rd_addr[p]];
         if ((BYPASS != 0) && wr_en && (bus.write_addr == rd_addr[p])) begin
            rd_data[p] = wr_merged;
         end
         if (!running || ((ZERO_REG != 0) && (rd_addr[p] == '0))) begin
            rd_data[p] = '0;
         end
         rd_busy[p] = running && pending_q[rd_addr[p]];
      end
   end

   assign bus.read_data_1 = rd_data[0];
   assign bus.read_data_2 = rd_data[1];
   assign bus.busy_1      = rd_busy[0];
   assign bus.busy_2      = rd_busy[1];
   assign bus.ready       = running;
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a default 32x32 instance (zero reg, bypass)
// and a 64-bit x 8 instance without zero reg or bypass.
module tb_regfile_param;
   logic clk = 1'b0;
   logic reset_a;
   logic reset_b;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [63:0] model_b [8];

   always #5 clk = ~clk;

   regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
   regfile_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) bus_b ();

   regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
      .clk   (clk),
      .reset (reset_a),
      .bus   (bus_a)
   );

   regfile_param #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
      .clk   (clk),
      .reset (reset_b),
      .bus   (bus_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walk n clear edges; ready must stay low until exactly edge n.
   task automatic poll_a(input int n);
      for (int i = 1; i <= n; i++) begin
         bus_a.read_addr_1 = 5'(i);
         #1;
         if (i < n) check($sformatf("a_clear_rd_%0d", i), 64'(bus_a.read_data_1), 64'd0);
         tick();
         check($sformatf("a_ready_edge_%0d", i), 64'(bus_a.ready), 64'(i == n));
      end
   endtask

   task automatic poll_b(input int n);
      for (int i = 1; i <= n; i++) begin
         tick();
         check($sformatf("b_ready_edge_%0d", i), 64'(bus_b.ready), 64'(i == n));
      end
   endtask

   task automatic write_a(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
      bus_a.write_addr = addr;
      bus_a.write_data = data;
      bus_a.byte_en    = be;
      bus_a.reg_write  = 1'b1;
      tick();
      bus_a.reg_write  = 1'b0;
   endtask

   task automatic read_a(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      bus_a.read_addr_1 = addr;
      bus_a.read_addr_2 = addr;
      #1;
      check({tag, "_p1"}, 64'(bus_a.read_data_1), 64'(exp));
      check({tag, "_p2"}, 64'(bus_a.read_data_2), 64'(exp));
   endtask

   initial begin
      logic [2:0]  addr;
      logic [63:0] data;
      logic [7:0]  be;

      reset_a = 1'b1;
      reset_b = 1'b1;
      bus_a.read_addr_1 = '0; bus_a.read_addr_2 = '0; bus_a.write_addr = '0;
      bus_a.write_data  = '0; bus_a.byte_en     = '0; bus_a.reg_write  = 1'b0;
      bus_a.reserve     = 1'b0; bus_a.reserve_addr = '0;
      bus_b.read_addr_1 = '0; bus_b.read_addr_2 = '0; bus_b.write_addr = '0;
      bus_b.write_data  = '0; bus_b.byte_en     = '0; bus_b.reg_write  = 1'b0;
      bus_b.reserve     = 1'b0; bus_b.reserve_addr = '0;
      tick();
      tick();

      // Reset values
      check("a_rst_ready", 64'(bus_a.ready), 64'd0);
      check("a_rst_busy1", 64'(bus_a.busy_1), 64'd0);
      check("a_rst_busy2", 64'(bus_a.busy_2), 64'd0);
      check("a_rst_rd1", 64'(bus_a.read_data_1), 64'd0);
      check("a_rst_rd2", 64'(bus_a.read_data_2), 64'd0);

      reset_a = 1'b0;
      poll_a(32);

      // Junk from a previous run must be gone after reset + clear
      write_a(5'd3, 32'hDEADBEEF, 4'hF);
      write_a(5'd20, 32'h55AA55AA, 4'hF);
      read_a("a_junk_r3", 5'd3, 32'hDEADBEEF);
      read_a("a_junk_r20", 5'd20, 32'h55AA55AA);
      reset_a = 1'b1;
      tick();
      reset_a = 1'b0;
      poll_a(32);
      read_a("a_cleared_r3", 5'd3, 32'd0);
      read_a("a_cleared_r20", 5'd20, 32'd0);

      // Reset mid-clear at clear_ptr=17 restarts the sequence
      write_a(5'd2, 32'h0BADCAFE, 4'hF);
      write_a(5'd25, 32'hFEEDFACE, 4'hF);
      reset_a = 1'b1;
      tick();
      reset_a = 1'b0;
      repeat (17) tick();
      reset_a = 1'b1;
      tick();
      reset_a = 1'b0;
      poll_a(32);
      for (int i = 0; i < 32; i++) begin
         bus_a.read_addr_1 = 5'(i);
         bus_a.read_addr_2 = 5'(31 - i);
         #1;
         check($sformatf("a_midclr_p1_r%0d", i), 64'(bus_a.read_data_1), 64'd0);
         check($sformatf("a_midclr_p2_r%0d", 31 - i), 64'(bus_a.read_data_2), 64'd0);
      end

      // Byte enables, including bypass of the merged word
      write_a(5'd5, 32'hAABBCCDD, 4'b1111);
      bus_a.read_addr_1 = 5'd5;
      bus_a.write_addr  = 5'd5;
      bus_a.write_data  = 32'h11223344;
      bus_a.byte_en     = 4'b0101;
      bus_a.reg_write   = 1'b1;
      #1;
      check("a_bypass_merge", 64'(bus_a.read_data_1), 64'hAA22CC44);
      tick();
      bus_a.reg_write = 1'b0;
      read_a("a_byte_merge_r5", 5'd5, 32'hAA22CC44);

      // Register 0 stays zero, even through bypass
      bus_a.read_addr_1 = 5'd0;
      bus_a.write_addr  = 5'd0;
      bus_a.write_data  = 32'hFFFFFFFF;
      bus_a.byte_en     = 4'hF;
      bus_a.reg_write   = 1'b1;
      #1;
      check("a_r0_bypass", 64'(bus_a.read_data_1), 64'd0);
      tick();
      bus_a.reg_write = 1'b0;
      read_a("a_r0_read", 5'd0, 32'd0);

      // Same-cycle bypass on r9
      write_a(5'd9, 32'h0BADF00D, 4'hF);
      bus_a.read_addr_1 = 5'd9;
      bus_a.read_addr_2 = 5'd9;
      bus_a.write_addr  = 5'd9;
      bus_a.write_data  = 32'h12345678;
      bus_a.byte_en     = 4'hF;
      bus_a.reg_write   = 1'b1;
      #1;
      check("a_bypass_r9_p1", 64'(bus_a.read_data_1), 64'h12345678);
      check("a_bypass_r9_p2", 64'(bus_a.read_data_2), 64'h12345678);
      tick();
      bus_a.reg_write = 1'b0;

      // Scoreboard
      bus_a.read_addr_1  = 5'd7;
      bus_a.read_addr_2  = 5'd7;
      bus_a.reserve      = 1'b1;
      bus_a.reserve_addr = 5'd7;
      #1;
      check("a_busy_same_cycle", 64'(bus_a.busy_1), 64'd0);
      tick();
      bus_a.reserve = 1'b0;
      #1;
      check("a_busy1_r7_set", 64'(bus_a.busy_1), 64'd1);
      check("a_busy2_r7_set", 64'(bus_a.busy_2), 64'd1);
      bus_a.write_addr = 5'd7;
      bus_a.write_data = 32'h77777777;
      bus_a.byte_en    = 4'h0;
      bus_a.reg_write  = 1'b1;
      #1;
      check("a_busy_no_bypass", 64'(bus_a.busy_1), 64'd1);
      tick();
      bus_a.reg_write = 1'b0;
      #1;
      check("a_busy_r7_cleared", 64'(bus_a.busy_1), 64'd0);
      check("a_r7_be0_data", 64'(bus_a.read_data_1), 64'd0);
      bus_a.reserve      = 1'b1;
      bus_a.reserve_addr = 5'd7;
      bus_a.byte_en      = 4'hF;
      bus_a.reg_write    = 1'b1;
      tick();
      bus_a.reserve   = 1'b0;
      bus_a.reg_write = 1'b0;
      #1;
      check("a_busy_reserve_wins", 64'(bus_a.busy_1), 64'd1);
      check("a_r7_data", 64'(bus_a.read_data_1), 64'h77777777);
      bus_a.reserve      = 1'b1;
      bus_a.reserve_addr = 5'd8;
      bus_a.reg_write    = 1'b1;
      tick();
      bus_a.reserve   = 1'b0;
      bus_a.reg_write = 1'b0;
      bus_a.read_addr_2 = 5'd8;
      #1;
      check("a_busy_r7_diff_addr", 64'(bus_a.busy_1), 64'd0);
      check("a_busy_r8_diff_addr", 64'(bus_a.busy_2), 64'd1);
      bus_a.reserve      = 1'b1;
      bus_a.reserve_addr = 5'd0;
      tick();
      bus_a.reserve     = 1'b0;
      bus_a.read_addr_1 = 5'd0;
      #1;
      check("a_busy_r0", 64'(bus_a.busy_1), 64'd0);

      // Reset discards a concurrent write and clears pending; reserve ignored in clear
      bus_a.write_addr   = 5'd12;
      bus_a.write_data   = 32'hCAFECAFE;
      bus_a.reg_write    = 1'b1;
      reset_a            = 1'b1;
      tick();
      reset_a            = 1'b0;
      bus_a.reg_write    = 1'b0;
      bus_a.read_addr_2  = 5'd8;
      #1;
      check("a_rst_clears_pending", 64'(bus_a.busy_2), 64'd0);
      bus_a.reserve      = 1'b1;
      bus_a.reserve_addr = 5'd11;
      poll_a(32);
      bus_a.reserve      = 1'b0;
      bus_a.read_addr_2  = 5'd11;
      #1;
      check("a_clear_ignores_reserve", 64'(bus_a.busy_2), 64'd0);
      read_a("a_r12_after_reset", 5'd12, 32'd0);

      // 64-bit x 8 instance: no zero register, no bypass
      reset_b = 1'b0;
      poll_b(8);
      for (int i = 0; i < 8; i++) model_b[i] = 64'd0;
      bus_b.write_addr = 3'd2;
      bus_b.write_data = 64'h0123456789ABCDEF;
      bus_b.byte_en    = 8'hFF;
      bus_b.reg_write  = 1'b1;
      tick();
      bus_b.read_addr_1 = 3'd2;
      bus_b.write_data  = 64'hFFEEDDCCBBAA9988;
      bus_b.byte_en     = 8'b1010_0101;
      #1;
      check("b_no_bypass", bus_b.read_data_1, 64'h0123456789ABCDEF);
      tick();
      bus_b.reg_write = 1'b0;
      #1;
      check("b_byte_merge", bus_b.read_data_1, 64'hFF23DD6789AACD88);
      model_b[2] = 64'hFF23DD6789AACD88;
      bus_b.write_addr = 3'd0;
      bus_b.write_data = 64'h0000_0000_0000_00A5;
      bus_b.byte_en    = 8'hFF;
      bus_b.reg_write  = 1'b1;
      tick();
      bus_b.reg_write   = 1'b0;
      bus_b.read_addr_2 = 3'd0;
      #1;
      check("b_r0_writable", bus_b.read_data_2, 64'hA5);
      model_b[0] = 64'hA5;

      // Random writes with random byte enables against a byte-wise model
      for (int k = 0; k < 24; k++) begin
         addr = 3'($urandom_range(0, 7));
         data = {$urandom, $urandom};
         be   = 8'($urandom_range(0, 255));
         bus_b.write_addr = addr;
         bus_b.write_data = data;
         bus_b.byte_en    = be;
         bus_b.reg_write  = 1'b1;
         tick();
         for (int j = 0; j < 8; j++) begin
            if (be[j]) model_b[addr][8*j +: 8] = data[8*j +: 8];
         end
      end
      bus_b.reg_write = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus_b.read_addr_1 = 3'(i);
         bus_b.read_addr_2 = 3'(7 - i);
         #1;
         check($sformatf("b_rand_p1_r%0d", i), bus_b.read_data_1, model_b[i]);
         check($sformatf("b_rand_p2_r%0d", 7 - i), bus_b.read_data_2, model_b[7 - i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
